// File: rtl/wb_pkg.sv
// Shared definitions for the write-back result stage.
//   SEL_*      : write-back source select encodings (5-7 are illegal)
//   LFMT_*     : load format codes (funct3)
//   wb_state_e : result-holding state machine states
//   off_width  : byte-offset width for a given data width
package wb_pkg;

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_PC4 = 3'd2;
  localparam logic [2:0] SEL_IMM = 3'd3;
  localparam logic [2:0] SEL_CSR = 3'd4;

  localparam logic [2:0] LFMT_LB  = 3'd0;
  localparam logic [2:0] LFMT_LH  = 3'd1;
  localparam logic [2:0] LFMT_LW  = 3'd2;
  localparam logic [2:0] LFMT_LD  = 3'd3;
  localparam logic [2:0] LFMT_LBU = 3'd4;
  localparam logic [2:0] LFMT_LHU = 3'd5;
  localparam logic [2:0] LFMT_LWU = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FULL     = 2'd2
  } wb_state_e;

  function automatic int off_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data aligner and extender.
//   raw    : raw aligned word from memory
//   fmt    : load format (LFMT_*)
//   offset : byte offset of the access inside the word
//   data   : shifted and sign/zero-extended load value
module load_formatter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [2:0]       fmt,
  input  logic [OFF_W-1:0] offset,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;

  // Misaligned offsets are shifted as given; no alignment check here.
  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    data = raw;
    case (fmt)
      LFMT_LB:  data = XLEN'($signed(shifted[7:0]));
      LFMT_LH:  data = XLEN'($signed(shifted[15:0]));
      LFMT_LBU: data = XLEN'(shifted[7:0]);
      LFMT_LHU: data = XLEN'(shifted[15:0]);
      // On a 32-bit core a word load is the whole word, passed unshifted.
      LFMT_LW:  if (XLEN != 32) data = XLEN'($signed(shifted[31:0]));
      LFMT_LWU: if (XLEN != 32) data = XLEN'(shifted[31:0]);
      default:  data = raw;
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// Registered write-back stage: selects the result source, formats load data
// (waiting for late memory data if needed) and holds one result behind a
// valid/ready handshake toward the register file.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : handshake from the execute stage
//   in_sel, in_load_fmt : source select and load format
//   in_alu/pc4/imm/csr  : candidate results (in_alu is also the load address)
//   in_rd, in_we        : destination register and write request
//   mem_rvalid/rdata    : load data return
//   out_valid/out_ready : handshake to the register file
//   out_data/rd/we      : write-back value, register, qualified enable
//   retire_count        : completed output handshakes (wraps)
//   err_illegal_sel     : pulse on accept of an illegal select
//   err_stray_rdata     : pulse on unexpected load data
//
// state       | meaning
// ST_EMPTY    | no result held, ready to accept
// ST_WAIT_MEM | load accepted, waiting for mem_rvalid
// ST_FULL     | result held and presented on out_*
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [2:0]       in_load_fmt,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_csr,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic [CNT_W-1:0] retire_count,
  output logic             err_illegal_sel,
  output logic             err_stray_rdata
);

  localparam int OFF_W = off_width(XLEN);

  wb_state_e        state, state_nxt;
  logic [XLEN-1:0]  data_q;
  logic [4:0]       rd_q;
  logic             we_q;
  logic [2:0]       fmt_q;
  logic [OFF_W-1:0] off_q;
  logic [CNT_W-1:0] retire_q;

  logic             accept, is_load, defer_load, mem_done;
  logic [2:0]       fmt_mux;
  logic [OFF_W-1:0] off_mux;
  logic [XLEN-1:0]  fmt_data, sel_data;

  // A pending load uses the latched format/offset; otherwise the live inputs.
  assign fmt_mux = (state == ST_WAIT_MEM) ? fmt_q : in_load_fmt;
  assign off_mux = (state == ST_WAIT_MEM) ? off_q : in_alu[OFF_W-1:0];

  load_formatter #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_formatter (
    .raw    (mem_rdata),
    .fmt    (fmt_mux),
    .offset (off_mux),
    .data   (fmt_data)
  );

  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    sel_data        = '0;
    err_illegal_sel = 1'b0;
    err_stray_rdata = 1'b0;

    case (state)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL:  in_ready = out_ready;
      default:  in_ready = 1'b0;
    endcase

    accept     = in_valid & in_ready;
    is_load    = (in_sel == SEL_MEM);
    defer_load = accept & is_load & ~mem_rvalid;
    mem_done   = (state == ST_WAIT_MEM) & mem_rvalid;

    case (in_sel)
      SEL_ALU: sel_data = in_alu;
      SEL_MEM: sel_data = fmt_data;
      SEL_PC4: sel_data = in_pc4;
      SEL_IMM: sel_data = in_imm;
      SEL_CSR: sel_data = in_csr;
      default: sel_data = '0;
    endcase

    case (state)
      ST_EMPTY:    if (accept) state_nxt = defer_load ? ST_WAIT_MEM : ST_FULL;
      ST_WAIT_MEM: if (mem_rvalid) state_nxt = ST_FULL;
      ST_FULL:
        if (out_ready) begin
          if (accept) state_nxt = defer_load ? ST_WAIT_MEM : ST_FULL;
          else        state_nxt = ST_EMPTY;
        end
      default:     state_nxt = ST_EMPTY;
    endcase

    // Pulses are suppressed while reset is held so reset reads all-zero.
    err_illegal_sel = ~reset & accept & (in_sel > SEL_CSR);
    err_stray_rdata = ~reset & mem_rvalid & (state != ST_WAIT_MEM) & ~(accept & is_load);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      fmt_q    <= '0;
      off_q    <= '0;
      retire_q <= '0;
    end else begin
      if (accept) begin
        rd_q <= in_rd;
        we_q <= in_we;
        if (defer_load) begin
          fmt_q <= in_load_fmt;
          off_q <= in_alu[OFF_W-1:0];
        end else begin
          data_q <= sel_data;
        end
      end else if (mem_done) begin
        data_q <= fmt_data;
      end
      if (out_valid & out_ready) retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign out_valid    = (state == ST_FULL);
  assign out_data     = data_q;
  assign out_rd       = rd_q;
  assign out_we       = out_valid & we_q & (rd_q != 5'd0);
  assign retire_count = retire_q;

endmodule
